// File: rtl/bp_train_sched.sv
// Retired-branch training scheduler: a FIFO of retired records for predictor training.
// It also repairs the global history register when a retired branch was mispredicted.
module bp_train_sched #(
  parameter int GH    = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                ret_valid_i,
  input  logic [1:0][31:0]          ret_pc_i,
  input  logic [1:0]                ret_taken_i,
  input  logic [1:0][31:0]          ret_target_i,
  input  logic [1:0][GH-1:0]        ret_ghr_i,
  input  logic [1:0]                ret_mispred_i,
  output logic                      ready_o,
  output logic                      train_valid_o,
  output logic [31:0]               train_pc_o,
  output logic                      train_actual_taken_o,
  output logic [31:0]               train_actual_target_o,
  output logic [GH-1:0]             train_ghr_snapshot_o,
  output logic                      recover_mispredict_pulse_o,
  output logic [GH-1:0]             recover_ghr_snapshot_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [15:0]               drop_count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: ready_o is a pure function of occupancy; a valid slot presented while
  // ready_o=0 is dropped, not stalled. train_valid_o has no ready: the head pops every
  // cycle it is valid.

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic          pulse_q, pulse_d;
  logic [GH-1:0] snap_q, snap_d;

  logic [31:0]   pc_mem     [DEPTH];
  logic          taken_mem  [DEPTH];
  logic [31:0]   target_mem [DEPTH];
  logic [GH-1:0] ghr_mem    [DEPTH];

  logic          slot1_ok;
  logic          push0, push1, pop;
  logic [1:0]    n_push, n_drop;
  logic [PW-1:0] wr1_idx;
  logic [16:0]   drop_sum;

  assign ready_o = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    // A mispredicted slot 0 squashes slot 1 entirely: it was on the wrong path.
    slot1_ok = ret_valid_i[1] & ~(ret_valid_i[0] & ret_mispred_i[0]);
    push0    = ready_o & ret_valid_i[0];
    push1    = ready_o & slot1_ok;
    n_push   = {1'b0, push0} + {1'b0, push1};
    n_drop   = ready_o ? 2'd0 : ({1'b0, ret_valid_i[0]} + {1'b0, slot1_ok});
    pop      = (count_q != '0);
    wr1_idx  = push0 ? (tail_q + PW'(1)) : tail_q;
    tail_d   = tail_q + PW'(n_push);
    head_d   = head_q + PW'(pop);
    count_d  = count_q + CW'(n_push) - CW'(pop);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    pulse_d = 1'b0;
    snap_d  = snap_q;
    if (ret_valid_i[0] & ret_mispred_i[0]) begin
      pulse_d = 1'b1;
      snap_d  = {ret_ghr_i[0][GH-2:0], ret_taken_i[0]};
    end else if (slot1_ok & ret_mispred_i[1]) begin
      pulse_d = 1'b1;
      snap_d  = {ret_ghr_i[1][GH-2:0], ret_taken_i[1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      pulse_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      pulse_q <= pulse_d;
      snap_q  <= snap_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push0) begin
        pc_mem[tail_q]     <= ret_pc_i[0];
        taken_mem[tail_q]  <= ret_taken_i[0];
        target_mem[tail_q] <= ret_target_i[0];
        ghr_mem[tail_q]    <= ret_ghr_i[0];
      end
      if (push1) begin
        pc_mem[wr1_idx]     <= ret_pc_i[1];
        taken_mem[wr1_idx]  <= ret_taken_i[1];
        target_mem[wr1_idx] <= ret_target_i[1];
        ghr_mem[wr1_idx]    <= ret_ghr_i[1];
      end
    end
  end

  assign train_valid_o              = pop;
  assign train_pc_o                 = pc_mem[head_q];
  assign train_actual_taken_o       = taken_mem[head_q];
  assign train_actual_target_o      = target_mem[head_q];
  assign train_ghr_snapshot_o       = ghr_mem[head_q];
  assign recover_mispredict_pulse_o = pulse_q;
  assign recover_ghr_snapshot_o     = snap_q;
  assign count_o                    = count_q;
  assign drop_count_o               = drop_q;

endmodule

// File: tb/tb_bp_train_sched.sv
// Randomized and directed bench for bp_train_sched against a queue-based reference model.
module tb_bp_train_sched;
  localparam int GH    = 8;
  localparam int DEPTH = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]         ret_valid_i;
  logic [1:0][31:0]   ret_pc_i;
  logic [1:0]         ret_taken_i;
  logic [1:0][31:0]   ret_target_i;
  logic [1:0][GH-1:0] ret_ghr_i;
  logic [1:0]         ret_mispred_i;
  logic               ready_o, train_valid_o, train_actual_taken_o;
  logic [31:0]        train_pc_o, train_actual_target_o;
  logic [GH-1:0]      train_ghr_snapshot_o, recover_ghr_snapshot_o;
  logic               recover_mispredict_pulse_o;
  logic [3:0]         count_o;
  logic [15:0]        drop_count_o;

  bp_train_sched #(.GH(GH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_taken_i(ret_taken_i),
    .ret_target_i(ret_target_i), .ret_ghr_i(ret_ghr_i), .ret_mispred_i(ret_mispred_i),
    .ready_o(ready_o), .train_valid_o(train_valid_o), .train_pc_o(train_pc_o),
    .train_actual_taken_o(train_actual_taken_o), .train_actual_target_o(train_actual_target_o),
    .train_ghr_snapshot_o(train_ghr_snapshot_o),
    .recover_mispredict_pulse_o(recover_mispredict_pulse_o),
    .recover_ghr_snapshot_o(recover_ghr_snapshot_o),
    .count_o(count_o), .drop_count_o(drop_count_o)
  );

  // scoreboard: each entry is {pc, taken, target, ghr}
  logic [72:0]   exp_q[$];
  int            m_drops;
  logic          m_pulse;
  logic [GH-1:0] m_snap;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: advance one clock edge using the inputs currently applied.
  task automatic model_step();
    int  n;
    int  nd;
    bit  rdy;
    bit  take1;
    bit  use_slot;
    if (reset) begin
      exp_q.delete();
      m_drops = 0;
      m_pulse = 1'b0;
      m_snap  = '0;
      return;
    end
    n     = exp_q.size();
    rdy   = (DEPTH - n) >= 2;
    nd    = 0;
    take1 = ret_valid_i[1] && !(ret_valid_i[0] && ret_mispred_i[0]);
    if (n != 0) void'(exp_q.pop_front());
    m_pulse = 1'b0;
    for (int s = 0; s < 2; s++) begin
      use_slot = (s == 0) ? ret_valid_i[0] : take1;
      if (use_slot) begin
        if (rdy) exp_q.push_back({ret_pc_i[s], ret_taken_i[s], ret_target_i[s], ret_ghr_i[s]});
        else nd++;
        if (ret_mispred_i[s] && !m_pulse) begin
          m_pulse = 1'b1;
          m_snap  = (ret_ghr_i[s] << 1) | GH'(ret_taken_i[s]);
        end
      end
    end
    m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
  endtask

  task automatic check_all();
    logic [72:0] h;
    chk("count", count_o, exp_q.size());
    chk("ready", ready_o, (DEPTH - exp_q.size()) >= 2);
    chk("train_valid", train_valid_o, exp_q.size() != 0);
    chk("drop_count", drop_count_o, m_drops);
    chk("pulse", recover_mispredict_pulse_o, m_pulse);
    chk("recover_snap", recover_ghr_snapshot_o, m_snap);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("train_pc", train_pc_o, h[72:41]);
      chk("train_taken", train_actual_taken_o, h[40]);
      chk("train_target", train_actual_target_o, h[39:8]);
      chk("train_ghr", train_ghr_snapshot_o, h[7:0]);
    end
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    ret_valid_i   = '0;
    ret_mispred_i = '0;
    ret_taken_i   = '0;
    ret_pc_i      = '0;
    ret_target_i  = '0;
    ret_ghr_i     = '0;
  endtask

  task automatic set_slot(input int s, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic [GH-1:0] ghr, input logic mis);
    ret_valid_i[s]   = 1'b1;
    ret_pc_i[s]      = pc;
    ret_taken_i[s]   = tk;
    ret_target_i[s]  = tgt;
    ret_ghr_i[s]     = ghr;
    ret_mispred_i[s] = mis;
  endtask

  initial begin
    int guard;
    int d0;
    checks   = 0;
    failures = 0;
    set_idle();
    reset = 1'b1;
    // reset state, inputs ignored
    set_slot(0, 32'h44, 1'b1, 32'h88, 8'h11, 1'b1);
    repeat (3) tick();
    chk("rst_count", count_o, 0);
    chk("rst_pulse", recover_mispredict_pulse_o, 0);
    set_idle();
    reset = 1'b0;

    // single record, accepted on first edge after reset
    set_slot(0, 32'h100, 1'b1, 32'h200, 8'h5A, 1'b0);
    tick();
    chk("single_pc", train_pc_o, 32'h100);
    chk("single_ghr", train_ghr_snapshot_o, 8'h5A);
    chk("single_count", count_o, 1);
    set_idle();
    tick();
    chk("single_drain", count_o, 0);

    // dual push ordering
    set_slot(0, 32'h10, 1'b0, 32'h1, 8'h01, 1'b0);
    set_slot(1, 32'h20, 1'b1, 32'h2, 8'h02, 1'b0);
    tick();
    chk("dual_first", train_pc_o, 32'h10);
    set_idle();
    tick();
    chk("dual_second", train_pc_o, 32'h20);
    tick();

    // fill until ready drops, then a dual push must be dropped
    guard = 0;
    do begin
      set_slot(0, 32'h1000 + guard, 1'b1, 32'h5, 8'h33, 1'b0);
      set_slot(1, 32'h2000 + guard, 1'b0, 32'h6, 8'h44, 1'b0);
      tick();
      guard++;
    end while (ready_o && guard < 20);
    chk("fill_ready_low", ready_o, 0);
    chk("fill_count", count_o, 7);
    d0 = m_drops;
    tick();
    chk("fill_drop_plus2", drop_count_o, d0 + 2);
    chk("fill_no_growth", count_o, 6);
    set_idle();
    repeat (8) tick();

    // mispredict in slot 0 squashes slot 1
    set_slot(0, 32'h300, 1'b0, 32'h304, 8'h81, 1'b1);
    set_slot(1, 32'h400, 1'b1, 32'h404, 8'hFF, 1'b1);
    tick();
    chk("mis0_pulse", recover_mispredict_pulse_o, 1);
    chk("mis0_snap", recover_ghr_snapshot_o, 8'h02);
    chk("mis0_count", count_o, 1);
    set_idle();
    tick();
    chk("mis0_pulse_end", recover_mispredict_pulse_o, 0);
    chk("mis0_snap_hold", recover_ghr_snapshot_o, 8'h02);

    // back-to-back mispredicts, second from slot 1
    set_slot(0, 32'h500, 1'b1, 32'h0, 8'h0F, 1'b1);
    tick();
    set_idle();
    set_slot(0, 32'h504, 1'b1, 32'h0, 8'h00, 1'b0);
    set_slot(1, 32'h508, 1'b1, 32'h0, 8'hC3, 1'b1);
    tick();
    chk("b2b_snap", recover_ghr_snapshot_o, 8'h87);
    set_idle();
    repeat (3) tick();

    // wrap-around stream
    for (int i = 0; i < 20; i++) begin
      set_slot(0, i, i[0], 32'h9000 + i, 8'(i), 1'b0);
      tick();
      chk("wrap_pc", train_pc_o, i);
    end
    set_idle();
    repeat (2) tick();

    // reset mid-stream with three queued and a pending pulse
    set_slot(0, 32'hA0, 1'b0, 32'h0, 8'h00, 1'b0);
    set_slot(1, 32'hA4, 1'b0, 32'h0, 8'h00, 1'b0);
    tick();
    set_slot(1, 32'hA8, 1'b1, 32'h0, 8'h40, 1'b1);
    tick();
    chk("mid_count3", count_o, 3);
    chk("mid_pulse", recover_mispredict_pulse_o, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", train_valid_o, 0);
    chk("mid_rst_pulse", recover_mispredict_pulse_o, 0);
    reset = 1'b0;
    set_idle();
    set_slot(0, 32'hB0, 1'b1, 32'hB4, 8'h12, 1'b0);
    tick();
    chk("post_rst_push", train_pc_o, 32'hB0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      set_idle();
      reset = ($urandom_range(0, 79) == 0);
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 3) != 0)
          set_slot(s, $urandom, 1'($urandom), $urandom, GH'($urandom),
                   ($urandom_range(0, 5) == 0));
      end
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/bp_train_sched.md
BP_TRAIN_SCHED -- requirements
Module: bp_train_sched

Interface
REQ-001 Parameter GH, default 8, global-history width; SHALL equal the predictor's GH.
REQ-002 Parameter DEPTH, default 8, queue entries; SHALL be a power of two, >= 4.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ret_valid_i  in  2  per-slot retired-branch valid; slot 0 is older.
REQ-006 ret_pc_i  in  2x32  per-slot branch PC.
REQ-007 ret_taken_i  in  2  per-slot resolved direction.
REQ-008 ret_target_i  in  2x32  per-slot resolved target.
REQ-009 ret_ghr_i  in  2xGH  per-slot GHR snapshot captured at prediction.
REQ-010 ret_mispred_i  in  2  per-slot mispredict flag.
REQ-011 ready_o  out  1  queue can absorb two records this cycle.
REQ-012 train_valid_o  out  1  train record presented to predictor.
REQ-013 train_pc_o  out  32  head PC.
REQ-014 train_actual_taken_o  out  1  head direction.
REQ-015 train_actual_target_o  out  32  head target.
REQ-016 train_ghr_snapshot_o  out  GH  head GHR snapshot.
REQ-017 recover_mispredict_pulse_o  out  1  one-cycle GHR-repair pulse.
REQ-018 recover_ghr_snapshot_o  out  GH  repaired GHR value.
REQ-019 count_o  out  clog2(DEPTH)+1  current occupancy.
REQ-020 drop_count_o  out  16  saturating count of dropped records.

Function
REQ-021 Circular FIFO of DEPTH records {pc, taken, target, ghr}; head and tail pointers wrap modulo DEPTH.
REQ-022 ready_o SHALL be combinational: 1 iff DEPTH - count_o >= 2.
REQ-023 When ready_o=1, each valid slot SHALL be pushed, slot 0 before slot 1; a lone slot-1 valid SHALL push one record.
REQ-024 If ret_valid_i[0] and ret_mispred_i[0] are both 1, slot 1 SHALL be ignored (not pushed, not counted, no recovery from it).
REQ-025 When ready_o=0, all valid, non-ignored slots SHALL be dropped; drop_count_o increments by the number dropped, saturating at 16'hFFFF.
REQ-026 train_valid_o SHALL equal (count_o != 0); train_* data SHALL reflect the head entry combinationally.
REQ-027 The predictor consumes unconditionally: whenever train_valid_o=1, the head SHALL be popped at that clock edge.
REQ-028 Push-to-train latency: a record pushed at edge N SHALL appear on train_* no earlier than the cycle after N; there is no empty bypass.
REQ-029 Same-cycle push and pop SHALL be legal; count_next = count + pushes - pop, range 0..DEPTH.
REQ-030 Recovery: the oldest valid, mispredicted, non-ignored slot s SHALL cause recover_mispredict_pulse_o=1 in the next cycle only, with recover_ghr_snapshot_o = {ret_ghr_i[s][GH-2:0], ret_taken_i[s]}.
REQ-031 Recovery SHALL occur even when that slot's record is dropped.
REQ-032 recover_ghr_snapshot_o SHALL hold its last value while the pulse is 0.
REQ-033 Back-to-back mispredicts in consecutive cycles SHALL produce consecutive pulses, each with its own snapshot.

Reset
REQ-034 While reset=1: head=tail=0, count_o=0, train_valid_o=0, recover_mispredict_pulse_o=0, recover_ghr_snapshot_o=0, drop_count_o=0, and inputs are ignored.
REQ-035 Reset asserted mid-operation SHALL discard all queued records and any pending pulse at the next edge; storage contents need not be cleared.
REQ-036 First push SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-037 Single record: ret_valid_i=01, pc=0x100, taken=1, target=0x200, ghr=0x5A -> next cycle train_valid_o=1 with those values, count_o=1; following cycle count_o=0.
REQ-038 Dual push ordering: slot0 pc=0x10, slot1 pc=0x20 in one cycle -> train_pc_o=0x10, then 0x20, on consecutive cycles.
REQ-039 Fill/drop: DEPTH=8, dual pushes for 4 consecutive cycles with pops -> occupancy peaks at 5 (2, 3, 4, 5, ready_o=1 throughout); to force count_o=7, hold dual pushes until ready_o=0, then apply a dual push -> drop_count_o increases by 2 and count_o does not increase.
REQ-040 Mispredict slot 0: ghr=0x81, taken=0, mispred=1, slot1 valid -> one push only; next cycle recover_mispredict_pulse_o=1, recover_ghr_snapshot_o=0x02; pulse 0 the cycle after.
REQ-041 Wrap-around: stream 20 single records pc=0..19 -> train_pc_o emits 0..19 in order with no loss.
REQ-042 Reset mid-stream with count_o=3 and a pending pulse -> next cycle count_o=0, train_valid_o=0, pulse=0.
